mem_read_arbiter: RTL and testbench
===================================

Name: mem_read_arbiter

Overview:
- Shares one AXI5-Lite read channel between two core read requesters:
  - requester 0 is instruction fetch (im_bus read side);
  - requester 1 is data load (dm_bus read side).
- Sits between the core and a unified single-port memory or interconnect.
- Accepts one address per transaction, forwards it downstream, and routes the single read response back to the requester that issued it.
- One transaction in flight at a time.

Parameters:
- XLEN, 32, data and address width.
- PROT_W, 3, width of the arprot fields.

Ports:
- clk  in  1  clock
- rstn  in  1  async active-low reset
- s0_arvalid  in  1  requester 0 address valid
- s0_arready  out  1  requester 0 address ready
- s0_araddr  in  XLEN  requester 0 address
- s0_arprot  in  PROT_W  requester 0 protection
- s0_rvalid  out  1  requester 0 read data valid
- s0_rready  in  1  requester 0 read data ready
- s0_rdata  out  XLEN  requester 0 read data
- s0_rresp  out  2  requester 0 response
- s1_*  same set as s0_*  requester 1 (data load)
- m_arvalid  out  1  downstream address valid
- m_arready  in  1  downstream address ready
- m_araddr  out  XLEN  downstream address
- m_arprot  out  PROT_W  downstream protection
- m_rvalid  in  1  downstream read valid
- m_rready  out  1  downstream read ready
- m_rdata  in  XLEN  downstream read data
- m_rresp  in  2  downstream response
- o_busy  out  1  high when state is not IDLE
- o_grant  out  1  index of the owning requester; valid while o_busy=1

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low, rstn.
- Reset values:
  - state = IDLE
  - m_arvalid = 0, m_araddr = 0, m_arprot = 0
  - o_grant = 0, o_busy = 0
  - all s*_arready and s*_rvalid = 0
  - round-robin pointer = 0 (requester 0 is preferred first)
- FSM IDLE -> ADDR -> RESP -> IDLE.
- IDLE:
  - Grant is combinational from s0_arvalid, s1_arvalid and the arbitration policy.
  - s*_arready = 1 only for the granted requester, and only when its arvalid = 1.
  - The accepted requester's araddr/arprot are registered into m_araddr/m_arprot; o_grant is registered.
  - Next state is ADDR.
- ADDR:
  - m_arvalid = 1; address and prot are held stable until m_arready.
  - On m_arvalid & m_arready: next state is RESP and m_arvalid clears.
- RESP:
  - m_rready = s<grant>_rready.
  - s<grant>_rvalid = m_rvalid; s<grant>_rdata = m_rdata; s<grant>_rresp = m_rresp. The response path is combinational (zero latency).
  - The non-granted requester sees rvalid = 0, rdata = 0 and rresp = 0.
  - On m_rvalid & m_rready: next state is IDLE.
- Minimum cost: 3 cycles from address acceptance to a return to IDLE, when downstream responds immediately. A new address can be accepted in the IDLE cycle that follows.
- While the FSM is outside IDLE, both s*_arready are held at 0, so a requester's arvalid stays pending.
- Outside RESP, m_rready = 0; an m_rvalid arriving outside RESP is ignored.
- m_rresp is passed through unmodified; error responses are not interpreted.
- Simultaneous s0 and s1 requests in IDLE are resolved by the arbitration policy (see Optional Feature).
- Reset asserted mid-transaction returns every output to its reset value immediately. The downstream transaction is abandoned; downstream must also be reset.
- A requester that drops arvalid before it is granted is legal; no state changes.

Optional Feature:
- Macro MEM_ARB_ROUND_ROBIN_EN.
- Defined:
  - Round-robin arbitration: the pointer flips to the other requester after each granted transaction.
  - On a tie, the requester the pointer selects wins.
  - With a single requester active, that requester is granted every time, regardless of the pointer.
- Undefined:
  - Fixed priority: requester 1 (data load) always wins ties.
  - Rationale: load completion unblocks the pipeline stall.
  - The pointer logic is absent.

Test Plan:
- Single fetch:
  - Stimulus: s0 araddr=0x100 with arvalid; downstream arready=1, then rvalid with rdata=0xDEADBEEF and rresp=0.
  - Required: m_araddr=0x100; s0 sees 0xDEADBEEF; s1_rvalid stays 0; o_busy low again after the response handshake.
- Simultaneous requests: s0=0x200 and s1=0x300 raised in the same cycle.
  - Fixed-priority build: 0x300 is issued first, then 0x200.
  - Round-robin build after reset: 0x200 is issued first, then 0x300.
- Backpressure: m_arready held 0 for 5 cycles.
  - Required: m_arvalid, m_araddr and m_arprot stay stable; s1 arvalid raised meanwhile sees arready=0 until return to IDLE.
- Response stall: s0_rready=0 for 4 cycles while m_rvalid=1.
  - Required: m_rready=0 and s0_rvalid=1 throughout; the handshake completes in the cycle s0_rready rises.
- Reset mid-RESP: rstn pulses low while in RESP.
  - Required: m_arvalid=0, m_rready=0, o_busy=0, all s*_rvalid=0 in the same cycle; the next request is handled normally.
- Round-robin alternation (round-robin build only): s0 and s1 arvalid held high continuously.
  - Required: grants alternate 0,1,0,1 over 4 transactions.

Source files
------------

// File: rtl/mem_read_arbiter_if.sv
// AXI5-Lite read channel (AR + R) between one requester and one completer.
interface mem_read_arbiter_if #(
  parameter int XLEN   = 32,
  parameter int PROT_W = 3
);
  logic              arvalid;
  logic              arready;
  logic [XLEN-1:0]   araddr;
  logic [PROT_W-1:0] arprot;
  logic              rvalid;
  logic              rready;
  logic [XLEN-1:0]   rdata;
  logic [1:0]        rresp;

  modport master (
    output arvalid, araddr, arprot, rready,
    input  arready, rvalid, rdata, rresp
  );

  modport slave (
    input  arvalid, araddr, arprot, rready,
    output arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/mem_read_arbiter.sv
// Two-requester AXI5-Lite read arbiter (s0 fetch, s1 load), one txn in flight.
// MEM_ARB_ROUND_ROBIN_EN selects round-robin; default gives s1 fixed priority.
module mem_read_arbiter #(
  parameter int XLEN   = 32,
  parameter int PROT_W = 3
) (
  input  logic                clk,
  input  logic                rstn,
  mem_read_arbiter_if.slave   s0,
  mem_read_arbiter_if.slave   s1,
  mem_read_arbiter_if.master  m,
  output logic                o_busy,
  output logic                o_grant
);

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    RESP
  } state_t;

  state_t            state;
  logic              arvalid_q;
  logic [XLEN-1:0]   araddr_q;
  logic [PROT_W-1:0] arprot_q;
  logic              req;
  logic              sel;
  logic              is_idle;
  logic              own0;
  logic              own1;

  assign req     = s0.arvalid | s1.arvalid;
  assign is_idle = (state == IDLE);
  assign own0    = (state == RESP) & ~o_grant;
  assign own1    = (state == RESP) &  o_grant;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic ptr;

  always_comb begin
    sel = s1.arvalid;
    if (s0.arvalid && s1.arvalid)
      sel = ptr;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      ptr <= 1'b0;
    else if (is_idle && req)
      ptr <= ~sel;
  end
`else
  assign sel = s1.arvalid;
`endif

  assign s0.arready = is_idle & s0.arvalid & ~sel;
  assign s1.arready = is_idle & s1.arvalid &  sel;

  assign m.arvalid = arvalid_q;
  assign m.araddr  = araddr_q;
  assign m.arprot  = arprot_q;

  // Response path is purely combinational to the owning requester.
  assign m.rready = (own0 & s0.rready) | (own1 & s1.rready);

  assign s0.rvalid = own0 & m.rvalid;
  assign s0.rdata  = own0 ? m.rdata : '0;
  assign s0.rresp  = own0 ? m.rresp : 2'b00;

  assign s1.rvalid = own1 & m.rvalid;
  assign s1.rdata  = own1 ? m.rdata : '0;
  assign s1.rresp  = own1 ? m.rresp : 2'b00;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      arvalid_q <= 1'b0;
      araddr_q  <= '0;
      arprot_q  <= '0;
      o_grant   <= 1'b0;
      o_busy    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req) begin
            state     <= ADDR;
            arvalid_q <= 1'b1;
            araddr_q  <= sel ? s1.araddr : s0.araddr;
            arprot_q  <= sel ? s1.arprot : s0.arprot;
            o_grant   <= sel;
            o_busy    <= 1'b1;
          end
        end
        ADDR: begin
          if (m.arready) begin
            state     <= RESP;
            arvalid_q <= 1'b0;
          end
        end
        RESP: begin
          if (m.rvalid && m.rready) begin
            state  <= IDLE;
            o_busy <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          arvalid_q <= 1'b0;
          o_busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_read_arbiter.sv
// Directed bench for mem_read_arbiter: vector table plus corner sequences.
module tb_mem_read_arbiter;

  logic clk;
  logic rstn;
  logic o_busy;
  logic o_grant;

  mem_read_arbiter_if #(.XLEN(32), .PROT_W(3)) s0_if ();
  mem_read_arbiter_if #(.XLEN(32), .PROT_W(3)) s1_if ();
  mem_read_arbiter_if #(.XLEN(32), .PROT_W(3)) m_if ();

  mem_read_arbiter #(.XLEN(32), .PROT_W(3)) dut (
    .clk     (clk),
    .rstn    (rstn),
    .s0      (s0_if),
    .s1      (s1_if),
    .m       (m_if),
    .o_busy  (o_busy),
    .o_grant (o_grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v0;
    logic        v1;
    logic [31:0] a0;
    logic [31:0] a1;
    logic [2:0]  p0;
    logic [2:0]  p1;
    logic [31:0] rd;
    logic [1:0]  rr;
    logic        g;
    logic [31:0] ea;
    logic [2:0]  ep;
  } vec_t;

  vec_t vt[6];
  int   nvec;
  int   nfail;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rst_pulse();
    rstn = 1'b0;
    step();
    step();
    rstn = 1'b1;
  endtask

  task automatic drain();
    for (int c = 0; c < 20; c++) begin
      if (!o_busy) break;
      step();
    end
    chk("drain_busy", o_busy, 0);
  endtask

  task automatic run_vec(input vec_t v);
    step();
    s0_if.arvalid = v.v0;
    s0_if.araddr  = v.a0;
    s0_if.arprot  = v.p0;
    s1_if.arvalid = v.v1;
    s1_if.araddr  = v.a1;
    s1_if.arprot  = v.p1;
    m_if.arready  = 1'b1;
    m_if.rvalid   = 1'b0;
    #1;
    chk("arready_win", v.g ? s1_if.arready : s0_if.arready, 1);
    chk("arready_lose", v.g ? s0_if.arready : s1_if.arready, 0);
    step();
    s0_if.arvalid = 1'b0;
    s1_if.arvalid = 1'b0;
    #1;
    chk("m_arvalid", m_if.arvalid, 1);
    chk("m_araddr", m_if.araddr, v.ea);
    chk("m_arprot", m_if.arprot, v.ep);
    chk("grant", o_grant, v.g);
    step();
    m_if.rvalid = 1'b1;
    m_if.rdata  = v.rd;
    m_if.rresp  = v.rr;
    #1;
    chk("rvalid_win", v.g ? s1_if.rvalid : s0_if.rvalid, 1);
    chk("rdata_win", v.g ? s1_if.rdata : s0_if.rdata, v.rd);
    chk("rresp_win", v.g ? s1_if.rresp : s0_if.rresp, v.rr);
    chk("rvalid_lose", v.g ? s0_if.rvalid : s1_if.rvalid, 0);
    chk("rdata_lose", v.g ? s0_if.rdata : s1_if.rdata, 0);
    chk("m_rready", m_if.rready, 1);
    step();
    m_if.rvalid = 1'b0;
    #1;
    chk("busy_end", o_busy, 0);
  endtask

  initial begin
    logic [31:0] got[$];
    logic        gg[$];
    logic        exp_g[4];
    bit          drop0;
    bit          drop1;

    nvec  = 0;
    nfail = 0;
    rstn  = 1'b0;
    s0_if.arvalid = 1'b0;
    s0_if.araddr  = '0;
    s0_if.arprot  = '0;
    s0_if.rready  = 1'b1;
    s1_if.arvalid = 1'b0;
    s1_if.araddr  = '0;
    s1_if.arprot  = '0;
    s1_if.rready  = 1'b1;
    m_if.arready  = 1'b1;
    m_if.rvalid   = 1'b0;
    m_if.rdata    = '0;
    m_if.rresp    = '0;

    vt[0] = '{1, 0, 32'h100, 32'h0, 3'd0, 3'd0,
              32'hDEADBEEF, 2'd0, 0, 32'h100, 3'd0};
    vt[1] = '{0, 1, 32'h0, 32'h1234, 3'd0, 3'd3,
              32'h0BADF00D, 2'd2, 1, 32'h1234, 3'd3};
`ifdef MEM_ARB_ROUND_ROBIN_EN
    vt[2] = '{1, 1, 32'h200, 32'h300, 3'd2, 3'd4,
              32'h11112222, 2'd0, 0, 32'h200, 3'd2};
`else
    vt[2] = '{1, 1, 32'h200, 32'h300, 3'd2, 3'd4,
              32'h11112222, 2'd0, 1, 32'h300, 3'd4};
`endif
    vt[3] = '{1, 1, 32'h400, 32'h500, 3'd1, 3'd5,
              32'h33334444, 2'd1, 1, 32'h500, 3'd5};
    vt[4] = '{1, 0, 32'h7FC, 32'h0, 3'd6, 3'd0,
              32'h55667788, 2'd3, 0, 32'h7FC, 3'd6};
    vt[5] = '{0, 1, 32'h0, 32'hFFFFFFFC, 3'd0, 3'd7,
              32'hFFFFFFFF, 2'd1, 1, 32'hFFFFFFFC, 3'd7};

    rst_pulse();

    // Reset state
    #1;
    chk("rst_busy", o_busy, 0);
    chk("rst_grant", o_grant, 0);
    chk("rst_m_arvalid", m_if.arvalid, 0);
    chk("rst_m_araddr", m_if.araddr, 0);
    chk("rst_m_arprot", m_if.arprot, 0);
    chk("rst_m_rready", m_if.rready, 0);
    chk("rst_s0_arready", s0_if.arready, 0);
    chk("rst_s1_arready", s1_if.arready, 0);
    chk("rst_s0_rvalid", s0_if.rvalid, 0);
    chk("rst_s1_rvalid", s1_if.rvalid, 0);

    // Simultaneous requests straight after reset, both held until granted
    step();
    s0_if.arvalid = 1'b1;
    s0_if.araddr  = 32'h200;
    s1_if.arvalid = 1'b1;
    s1_if.araddr  = 32'h300;
    m_if.rvalid   = 1'b1;
    m_if.rdata    = 32'h0;
    drop0 = 1'b0;
    drop1 = 1'b0;
    for (int c = 0; c < 20 && got.size() < 2; c++) begin
      if (c > 0) step();
      if (drop0) s0_if.arvalid = 1'b0;
      if (drop1) s1_if.arvalid = 1'b0;
      #1;
      drop0 = drop0 | (s0_if.arvalid & s0_if.arready);
      drop1 = drop1 | (s1_if.arvalid & s1_if.arready);
      if (m_if.arvalid && m_if.arready) got.push_back(m_if.araddr);
    end
    chk("tie_count", got.size(), 2);
    if (got.size() == 2) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      chk("tie_first", got[0], 32'h200);
      chk("tie_second", got[1], 32'h300);
`else
      chk("tie_first", got[0], 32'h300);
      chk("tie_second", got[1], 32'h200);
`endif
    end
    s0_if.arvalid = 1'b0;
    s1_if.arvalid = 1'b0;
    drain();
    m_if.rvalid = 1'b0;

    for (int i = 0; i < 6; i++) run_vec(vt[i]);

    // Address backpressure, then response stall
    step();
    s0_if.arvalid = 1'b1;
    s0_if.araddr  = 32'h600;
    s0_if.arprot  = 3'd2;
    m_if.arready  = 1'b0;
    m_if.rvalid   = 1'b0;
    #1;
    chk("bp_s0_arready", s0_if.arready, 1);
    step();
    s0_if.arvalid = 1'b0;
    s1_if.arvalid = 1'b1;
    s1_if.araddr  = 32'h700;
    s1_if.arprot  = 3'd1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_m_arvalid", m_if.arvalid, 1);
      chk("bp_m_araddr", m_if.araddr, 32'h600);
      chk("bp_m_arprot", m_if.arprot, 3'd2);
      chk("bp_s1_arready", s1_if.arready, 0);
      step();
    end
    m_if.arready = 1'b1;
    step();
    m_if.rvalid   = 1'b1;
    m_if.rdata    = 32'hCAFE0001;
    m_if.rresp    = 2'd0;
    s0_if.rready  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("stall_m_rready", m_if.rready, 0);
      chk("stall_s0_rvalid", s0_if.rvalid, 1);
      chk("stall_s1_arready", s1_if.arready, 0);
      step();
    end
    s0_if.rready = 1'b1;
    #1;
    chk("stall_release", m_if.rready, 1);
    chk("stall_rdata", s0_if.rdata, 32'hCAFE0001);
    step();
    m_if.rvalid = 1'b0;
    #1;
    chk("post_busy", o_busy, 0);
    chk("post_s1_arready", s1_if.arready, 1);
    step();
    s1_if.arvalid = 1'b0;
    #1;
    chk("s1_araddr", m_if.araddr, 32'h700);
    chk("s1_grant", o_grant, 1);
    step();
    m_if.rvalid = 1'b1;
    m_if.rdata  = 32'h5A5A5A5A;
    #1;
    chk("s1_rdata", s1_if.rdata, 32'h5A5A5A5A);
    chk("s1_s0_rvalid", s0_if.rvalid, 0);
    step();
    m_if.rvalid = 1'b0;
    #1;
    chk("s1_done_busy", o_busy, 0);

    // Reset while in RESP
    step();
    s0_if.arvalid = 1'b1;
    s0_if.araddr  = 32'h800;
    s0_if.rready  = 1'b0;
    step();
    s0_if.arvalid = 1'b0;
    step();
    m_if.rvalid = 1'b1;
    m_if.rdata  = 32'h11;
    #1;
    chk("mr_s0_rvalid", s0_if.rvalid, 1);
    chk("mr_busy", o_busy, 1);
    #1;
    rstn = 1'b0;
    #1;
    chk("mr_m_arvalid", m_if.arvalid, 0);
    chk("mr_m_rready", m_if.rready, 0);
    chk("mr_busy_rst", o_busy, 0);
    chk("mr_s0_rvalid_rst", s0_if.rvalid, 0);
    chk("mr_s1_rvalid_rst", s1_if.rvalid, 0);
    step();
    step();
    rstn = 1'b1;
    m_if.rvalid  = 1'b0;
    s0_if.rready = 1'b1;
    run_vec('{1, 0, 32'h900, 32'h0, 3'd3, 3'd0,
              32'h99AA, 2'd0, 0, 32'h900, 3'd3});

    // Continuous contention from both requesters
    rst_pulse();
`ifdef MEM_ARB_ROUND_ROBIN_EN
    exp_g = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
    exp_g = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
    s0_if.arvalid = 1'b1;
    s0_if.araddr  = 32'hA00;
    s1_if.arvalid = 1'b1;
    s1_if.araddr  = 32'hB00;
    m_if.arready  = 1'b1;
    m_if.rvalid   = 1'b1;
    for (int c = 0; c < 40 && gg.size() < 4; c++) begin
      #1;
      if (m_if.arvalid) gg.push_back(o_grant);
      step();
    end
    chk("alt_count", gg.size(), 4);
    if (gg.size() == 4)
      for (int i = 0; i < 4; i++) chk("alt_grant", gg[i], exp_g[i]);
    s0_if.arvalid = 1'b0;
    s1_if.arvalid = 1'b0;
    drain();
    m_if.rvalid = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
